// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer: PC, memory handshake, instruction hold and fault
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        ins_valid,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    input  logic        ins_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] PC,
    output logic        fault
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

    logic [2:0]    state;
    logic [31:0]   pc;
    logic [TW-1:0] tcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            pc     <= RESET_PC;
            ins    <= 32'h0;
            ins_pc <= 32'h0;
            tcnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en)
                        state <= S_REQ;
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        state <= S_WAIT;
                        tcnt  <= '0;
                    end
                end
                S_WAIT: begin
                    // Data wins over a timeout landing on the same cycle.
                    if (mem_rvalid) begin
                        ins    <= mem_rdata;
                        ins_pc <= pc;
                        state  <= S_HOLD;
                    end else if (tcnt == TCNT_LAST) begin
                        state <= S_ERR;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (ins_ready) begin
                        if (redirect && (redirect_pc[1:0] != 2'b00)) begin
                            state <= S_ERR;
                        end else begin
                            pc    <= redirect ? redirect_pc : pc + 32'd4;
                            state <= en ? S_REQ : S_IDLE;
                        end
                    end
                end
                S_ERR: begin
                    state <= S_ERR;
                end
                default: begin
                    state <= S_ERR;
                end
            endcase
        end
    end

    assign mem_req   = (state == S_REQ);
    assign mem_addr  = pc;
    assign ins_valid = (state == S_HOLD);
    assign PC        = pc;
    assign fault     = (state == S_ERR);

endmodule
